// File: rtl/shift_out_reg.sv
// Parallel-in / serial-out read-out register with a valid/ready serial port.
// Captures a word in IDLE, streams it one bit per accepted transfer, then pulses done.
`timescale 1ns/1ps
module shift_out_reg #(
    parameter int n         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in,
    input  logic         load,
    input  logic         clr,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         busy,
    output logic         done
);
    function automatic int f_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    localparam int CW = (f_clog2(n + 1) < 1) ? 1 : f_clog2(n + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [n-1:0]    r_shreg;
    logic [CW-1:0]   r_count;
    logic            w_accept;
    logic            w_capture;
    logic            w_last;
    logic            w_bit;

    assign w_accept  = (r_state == S_SHIFT) && sout_ready;
    assign w_capture = (r_state == S_IDLE) && load;
    assign w_last    = w_accept && (r_count == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // clr is active-low and outranks every other request on the same edge
    always_comb begin
        w_next = r_state;
        if (!clr) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (load)   w_next = S_SHIFT;
                S_SHIFT: if (w_last) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (!clr) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_capture) begin
            r_shreg <= in;
            r_count <= CW'(n);
        end else if (w_accept) begin
            r_shreg <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Outputs are pure decodes of registered state; sout_ready never reaches them
    assign w_bit      = MSB_FIRST ? r_shreg[n-1] : r_shreg[0];
    assign sout       = (r_state == S_SHIFT) && w_bit;
    assign sout_valid = (r_state == S_SHIFT);
    assign busy       = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign done       = (r_state == S_DONE);

endmodule
